// File: rtl/vec_mul_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// vec_mul_pkg
// Shared types and default sizing for the vector multiplier sequencer.
//   seq_state_t     : sequencer states (IDLE, CLEAR, RUN, DRAIN, DONE)
//   VEC_LEN_DEF     : default elements per vector
//   IDX_W_DEF       : default width of the element index
//   PIPE_DEPTH_DEF  : default multiplier/accumulator pipeline latency
// ---------------------------------------------------------------------------
package vec_mul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int VEC_LEN_DEF    = 16;
    localparam int IDX_W_DEF      = 5;
    localparam int PIPE_DEPTH_DEF = 3;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// vec_mul_sequencer_if
// Control/handshake bundle between the sequencer and its surroundings
// (start requester, operand fetch, MAC pipeline, result consumer).
//   start_valid / start_ready : start handshake
//   abort                     : synchronous abort request
//   operand_valid             : operands for elem_idx are available
//   acc_clr                   : one-cycle accumulator clear
//   issue_valid / elem_idx    : element issue to fetch + MAC pipeline
//   busy                      : sequencer not idle
//   done_valid / done_ready   : completion handshake
// Modports:
//   master : the sequencer, which drives the issue/status side
//   slave  : the environment that requests runs and consumes results
// ---------------------------------------------------------------------------
interface vec_mul_sequencer_if
    import vec_mul_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);

    logic             start_valid;
    logic             start_ready;
    logic             abort;
    logic             operand_valid;
    logic             acc_clr;
    logic             issue_valid;
    logic [IDX_W-1:0] elem_idx;
    logic             busy;
    logic             done_valid;
    logic             done_ready;

    modport master (
        input  start_valid,
        input  abort,
        input  operand_valid,
        input  done_ready,
        output start_ready,
        output acc_clr,
        output issue_valid,
        output elem_idx,
        output busy,
        output done_valid
    );

    modport slave (
        output start_valid,
        output abort,
        output operand_valid,
        output done_ready,
        input  start_ready,
        input  acc_clr,
        input  issue_valid,
        input  elem_idx,
        input  busy,
        input  done_valid
    );

endinterface

// File: rtl/vec_mul_sequencer_idx_counter.sv
// ---------------------------------------------------------------------------
// seq_idx_counter
// Up-counter with synchronous clear and increment-enable; holds otherwise.
// Clear has priority over increment.
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset, count returns to 0
//   clr_i   : synchronous clear
//   inc_i   : increment by one
//   count_o : current count
// ---------------------------------------------------------------------------
module seq_idx_counter
    import vec_mul_pkg::*;
#(
    parameter int WIDTH = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vec_mul_sequencer.sv
// ---------------------------------------------------------------------------
// vec_mul_sequencer
// Control sequencer for the pipelined vector multiplier. On an accepted start
// it clears the accumulator for one cycle, issues element indices
// 0..VEC_LEN-1 (stalling while operands are unavailable), waits PIPE_DEPTH
// cycles for the pipeline to drain and then holds done_valid until the
// consumer acknowledges it. abort returns any state to IDLE.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : vec_mul_sequencer_if.master (handshake/issue/status signals)
// ---------------------------------------------------------------------------
module vec_mul_sequencer
    import vec_mul_pkg::*;
#(
    parameter int VEC_LEN    = VEC_LEN_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    vec_mul_sequencer_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(VEC_LEN - 1);
    localparam logic [3:0]       DRAIN_LOAD = 4'(PIPE_DEPTH - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [3:0]       drain_q;
    logic [3:0]       drain_d;
    logic [IDX_W-1:0] elemIdx;
    logic             issueFire;
    logic             lastIssue;
    logic             idxClear;

    assign issueFire = (state_q == RUN) && bus.operand_valid;
    assign lastIssue = issueFire && (elemIdx == LAST_IDX);

    // Keeping the index cleared outside RUN guarantees it reads 0 in every
    // other state and is already 0 on entry to RUN. The final issue clears
    // it instead of incrementing, so the counter never wraps inside a run.
    assign idxClear = (state_q != RUN) || bus.abort || lastIssue;

    seq_idx_counter #(
        .WIDTH (IDX_W)
    ) u_idx_counter (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (idxClear),
        .inc_i   (issueFire),
        .count_o (elemIdx)
    );

    // Next-state and drain-counter logic. The drain counter is loaded with
    // PIPE_DEPTH-1 together with the move into DRAIN and DONE follows the
    // cycle in which it reads 0, giving exactly PIPE_DEPTH drain cycles.
    // abort is applied last so it overrides every other transition.
    always_comb begin
        state_d = state_q;
        drain_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (lastIssue) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = IDLE;
            drain_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // All outputs decode the state register directly, so an asynchronous
    // reset forces them to their idle values without waiting for a clock.
    assign bus.start_ready = (state_q == IDLE);
    assign bus.acc_clr     = (state_q == CLEAR);
    assign bus.issue_valid = issueFire;
    assign bus.elem_idx    = elemIdx;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done_valid  = (state_q == DONE);

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_mul_sequencer
// Self-checking bench for vec_mul_sequencer. A default-parameter instance is
// exercised with directed and randomized runs whose expected behaviour is
// derived as a timeline from the sequencer's timing rules; a second instance
// (VEC_LEN=1, PIPE_DEPTH=1) covers the minimum-size corner.
// ---------------------------------------------------------------------------
module tb_vec_mul_sequencer;

    localparam int VL = 16;
    localparam int PD = 3;
    localparam int IW = 5;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    vec_mul_sequencer_if #(.IDX_W(IW)) bus  ();
    vec_mul_sequencer_if #(.IDX_W(IW)) busE ();

    vec_mul_sequencer #(
        .VEC_LEN    (VL),
        .IDX_W      (IW),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    vec_mul_sequencer #(
        .VEC_LEN    (1),
        .IDX_W      (IW),
        .PIPE_DEPTH (1)
    ) dutEdge (
        .clk  (clk),
        .rstn (rstn),
        .bus  (busE.master)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the main instance's inputs for the cycle following the next edge.
    task automatic applyStimulus(input logic sv, input logic ab,
                                 input logic ov, input logic dr);
        @(posedge clk);
        #1;
        bus.start_valid   = sv;
        bus.abort         = ab;
        bus.operand_valid = ov;
        bus.done_ready    = dr;
    endtask

    // One complete run starting in IDLE. Cycle r=0 is the accept cycle.
    // The model: issues happen on the first VEC_LEN cycles from r=2 on which
    // operand_valid is high; DRAIN spans PD cycles after the last issue;
    // done_valid then holds until the cycle done_ready is high.
    // mode 0: no stalls, mode 1: 3-cycle stall at elem_idx 7, mode 2: random.
    task automatic runTransaction(input int mode, input int ackDelay);
        bit opv [0:255];
        int nIss;
        int lastRel;
        int doneRel;
        int ackRel;
        int stalls;
        int modelIss;
        int dutIss;
        int doneRises;
        int firstDone;
        logic prevDone;
        logic sv, ov, dr;
        logic expIssue;
        int expIdx;
        for (int r = 0; r < 256; r++) begin
            if (mode == 0) opv[r] = 1'b1;
            else if (mode == 1) opv[r] = !(r >= 9 && r <= 11);
            else opv[r] = (r >= 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        nIss = 0;
        lastRel = 0;
        stalls = 0;
        for (int r = 2; r < 256 && nIss < VL; r++) begin
            if (opv[r]) begin
                nIss++;
                if (nIss == VL) lastRel = r;
            end else begin
                stalls++;
            end
        end
        doneRel   = lastRel + PD + 1;
        ackRel    = doneRel + ackDelay;
        modelIss  = 0;
        dutIss    = 0;
        doneRises = 0;
        firstDone = -1;
        prevDone  = 1'b0;
        for (int r = 0; r <= ackRel; r++) begin
            sv = (r == 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
            ov = (r >= 2 && r <= lastRel) ? opv[r] : 1'(($urandom_range(0, 1)));
            if (r < doneRel) dr = 1'($urandom_range(0, 1));
            else dr = (r == ackRel);
            applyStimulus(sv, 1'b0, ov, dr);
            @(negedge clk);
            expIssue = (r >= 2) && (r <= lastRel) && ov;
            expIdx   = (r >= 2 && r <= lastRel) ? modelIss : 0;
            checkOutput($sformatf("m%0d r%0d start_ready", mode, r), bus.start_ready, r == 0);
            checkOutput($sformatf("m%0d r%0d busy", mode, r), bus.busy, r != 0);
            checkOutput($sformatf("m%0d r%0d acc_clr", mode, r), bus.acc_clr, r == 1);
            checkOutput($sformatf("m%0d r%0d issue_valid", mode, r), bus.issue_valid, expIssue);
            checkOutput($sformatf("m%0d r%0d elem_idx", mode, r), bus.elem_idx, expIdx);
            checkOutput($sformatf("m%0d r%0d done_valid", mode, r), bus.done_valid,
                        (r >= doneRel) && (r <= ackRel));
            if (expIssue) modelIss++;
            if (bus.issue_valid) dutIss++;
            if (bus.done_valid && !prevDone) begin
                doneRises++;
                if (firstDone < 0) firstDone = r;
            end
            prevDone = bus.done_valid;
        end
        checkOutput($sformatf("m%0d issueCount", mode), dutIss, VL);
        checkOutput($sformatf("m%0d doneCount", mode), doneRises, 1);
        checkOutput($sformatf("m%0d doneLatency", mode), firstDone, 2 + VL + PD + stalls);
    endtask

    // Abort mid-RUN at elem_idx 5 with a simultaneous start request.
    task automatic runAbortRun();
        int doneSeen;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 6; r++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abortRun idxBefore", bus.elem_idx, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("abortRun busy", bus.busy, 0);
        checkOutput("abortRun elem_idx", bus.elem_idx, 0);
        checkOutput("abortRun start_ready", bus.start_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("abortRun noStartAccept acc_clr", bus.acc_clr, 0);
        checkOutput("abortRun noStartAccept busy", bus.busy, 0);
        doneSeen = 0;
        for (int r = 0; r < 30; r++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            if (bus.done_valid || bus.busy) doneSeen++;
        end
        checkOutput("abortRun quiet", doneSeen, 0);
    endtask

    // Abort while draining; the completion must be discarded.
    task automatic runAbortDrain();
        int doneSeen;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 18; r++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abortDrain inDrain busy", bus.busy, 1);
        checkOutput("abortDrain inDrain done", bus.done_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        doneSeen = 0;
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.done_valid) doneSeen++;
        end
        checkOutput("abortDrain noDone", doneSeen, 0);
        checkOutput("abortDrain idle", bus.start_ready, 1);
    endtask

    // Asynchronous reset while in DRAIN.
    task automatic runResetDrain();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int r = 1; r <= 18; r++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("resetDrain preBusy", bus.busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("resetDrain busy", bus.busy, 0);
        checkOutput("resetDrain acc_clr", bus.acc_clr, 0);
        checkOutput("resetDrain issue_valid", bus.issue_valid, 0);
        checkOutput("resetDrain elem_idx", bus.elem_idx, 0);
        checkOutput("resetDrain done_valid", bus.done_valid, 0);
        bus.operand_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("resetDrain start_ready", bus.start_ready, 1);
        checkOutput("resetDrain busyAfter", bus.busy, 0);
    endtask

    // VEC_LEN=1, PIPE_DEPTH=1: one issue at T+2 and done_valid at T+4.
    task automatic runEdge();
        for (int r = 0; r <= 5; r++) begin
            @(posedge clk);
            #1;
            busE.start_valid   = (r == 0);
            busE.operand_valid = 1'b1;
            busE.done_ready    = (r == 4);
            @(negedge clk);
            checkOutput($sformatf("edge r%0d issue_valid", r), busE.issue_valid, r == 2);
            checkOutput($sformatf("edge r%0d done_valid", r), busE.done_valid, r == 4);
            checkOutput($sformatf("edge r%0d busy", r), busE.busy, (r >= 1) && (r <= 4));
            checkOutput($sformatf("edge r%0d elem_idx", r), busE.elem_idx, 0);
        end
        checkOutput("edge idle start_ready", busE.start_ready, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.start_valid    = 1'b0;
        bus.abort          = 1'b0;
        bus.operand_valid  = 1'b0;
        bus.done_ready     = 1'b0;
        busE.start_valid   = 1'b0;
        busE.abort         = 1'b0;
        busE.operand_valid = 1'b0;
        busE.done_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done_valid", bus.done_valid, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("reset start_ready", bus.start_ready, 1);
        checkOutput("reset acc_clr", bus.acc_clr, 0);
        checkOutput("reset issue_valid", bus.issue_valid, 0);
        checkOutput("reset elem_idx", bus.elem_idx, 0);

        runTransaction(0, 2);
        runTransaction(1, 0);
        for (int i = 0; i < 6; i++) runTransaction(2, $urandom_range(0, 4));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runAbortRun();
        runAbortDrain();
        runResetDrain();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        runEdge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_mul_sequencer.md
# vec_mul_sequencer

Control sequencer for the 16x16 pipelined vector multiplier. It accepts a start request and clears the accumulator. It then issues element indices 0..VEC_LEN-1 to the operand fetch and MAC pipeline, stalling on operand availability. After the last issue it drains the pipeline and holds a done flag until the consumer acknowledges it.

## Interface
Parameters:
- VEC_LEN, 16, elements per vector; legal range 1..2**IDX_W.
- IDX_W, 5, width of elem_idx.
- PIPE_DEPTH, 3, multiplier/accumulator pipeline latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start_valid  in  1  start request.
- start_ready  out  1  high only in IDLE; a start is accepted when start_valid & start_ready.
- abort  in  1  synchronous abort; any state returns to IDLE next cycle.
- operand_valid  in  1  operands for the current elem_idx are available.
- acc_clr  out  1  one-cycle accumulator clear.
- issue_valid  out  1  elem_idx is being consumed this cycle (RUN & operand_valid).
- elem_idx  out  IDX_W  current element index.
- busy  out  1  state is not IDLE.
- done_valid  out  1  result is complete in the accumulator.
- done_ready  in  1  consumer acknowledge of done_valid.

## Operation
States: IDLE, CLEAR, RUN, DRAIN, DONE.

Transitions:
- IDLE -> CLEAR on start accept.
- CLEAR -> RUN unconditionally after 1 cycle.
- RUN -> DRAIN when issue_valid and elem_idx == VEC_LEN-1.
- DRAIN -> DONE when the drain counter reaches 0.
- DONE -> IDLE when done_ready.
- Any state -> IDLE when abort. abort has priority over every other condition, including a same-cycle start.

Outputs by state:
- acc_clr = (state == CLEAR). Combinational from the state register.
- issue_valid = (state == RUN) & operand_valid. Combinational, no stall latency.

Index counter:
- Set to 0 on entry to RUN.
- Increments by 1 on each issue_valid.
- Holds when operand_valid is low.
- Never wraps inside a run; the increment from VEC_LEN-1 is replaced by the transition to DRAIN, and elem_idx returns to 0.
- elem_idx is 0 in every state other than RUN.

Drain counter:
- Loaded with PIPE_DEPTH-1 on entry to DRAIN.
- Decrements once per cycle.
- DONE is entered on the cycle after it reads 0, so DRAIN lasts exactly PIPE_DEPTH cycles.

Other rules:
- done_valid = (state == DONE). It stays high until done_ready; holding done_ready high constantly is legal.
- A start_valid asserted while busy is ignored (start_ready is low) and is not queued.
- Abort in DRAIN or DONE discards the completion; done_valid must not assert afterward.
- operand_valid is ignored outside RUN.

Reset values: state IDLE, elem_idx 0, drain counter 0, acc_clr 0, issue_valid 0, busy 0, done_valid 0. start_ready is 1 immediately after reset release, because it is combinational from IDLE.

## Timing
- Start accepted at cycle T gives acc_clr at T+1 and the first issue (elem_idx 0) at T+2.
- With no stalls:
  - last issue at T+1+VEC_LEN;
  - DRAIN over T+2+VEC_LEN .. T+1+VEC_LEN+PIPE_DEPTH;
  - done_valid first high at T+2+VEC_LEN+PIPE_DEPTH (T+21 for the defaults).
- Each cycle with operand_valid low in RUN adds exactly one cycle to that total.
- If done_ready is high during the first DONE cycle, the state returns to IDLE the next cycle, so done_valid is high for exactly 1 cycle.
- A new start can be accepted on the first IDLE cycle: back-to-back runs with no gap cycle beyond IDLE.
- Asserting rstn low at any time forces all outputs to their reset values without waiting for a clock edge.

## Structure
- Package vec_mul_pkg holds:
  - seq_state_t (enum IDLE, CLEAR, RUN, DRAIN, DONE, 3-bit);
  - constants VEC_LEN_DEF = 16, IDX_W_DEF = 5, PIPE_DEPTH_DEF = 3.
- Sub-module seq_idx_counter: IDX_W-bit counter with synchronous clear, increment and hold (priority clear > inc), async active-low reset to 0.
  - The sequencer instantiates it for elem_idx.
  - The drain counter is a small inline 4-bit down-counter.

## Test plan
- Nominal run, defaults, operand_valid tied high, start at cycle 10:
  - acc_clr at cycle 11;
  - elem_idx 0..15 with issue_valid on cycles 12..27;
  - done_valid at cycle 31;
  - done_ready at cycle 33 gives IDLE and start_ready = 1 at cycle 34.
- Stalls: operand_valid low for 3 cycles while elem_idx == 7.
  - elem_idx holds at 7 and issue_valid stays low during the stall.
  - Exactly 16 issue pulses occur in total.
  - done_valid arrives 3 cycles later than nominal.
- Abort mid-RUN at elem_idx == 5, with start_valid also high that cycle:
  - next cycle IDLE, elem_idx 0, busy 0, no done_valid;
  - the simultaneous start is not accepted.
- Start while busy: pulse start_valid during RUN.
  - Ignored; exactly one completion results.
  - A back-to-back start on the first IDLE cycle is accepted.
- Async reset asserted in DRAIN: all outputs go to 0 immediately and start_ready = 1 after release. Edge case VEC_LEN = 1, PIPE_DEPTH = 1: one issue at T+2 and done_valid at T+4.
